enc_key_schedule_256_seq: RTL and testbench
===========================================

Name: enc_key_schedule_256_seq

Overview:
- Sequential encryption-direction round-key generator for SWAN64 with a 256-bit key. It is the forward counterpart of the combinational decryption key-schedule step.
- Loads master key and initial delta, then emits ROUNDS 32-bit round keys one per valid/ready handshake.
- On completion it exposes the final key/delta state. That state is the starting state for the decryption schedule, which then reproduces the round keys in reverse order.
- Sits between the key-load interface and the SWAN64 encryption round datapath.

Parameters:
- BLOCK_SIZE, 64, cipher block width
- SIDE_SIZE, BLOCK_SIZE/2 = 32, round-key and delta width
- KEY_SIZE, 256, key register width
- PD, 24, per-round key rotation amount (bits)
- DELTA0, 32'h9e3779b9, delta increment per round
- ROUNDS, 64, round keys produced per run
- CNT_W, 7, round counter width (must hold ROUNDS)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  load request, sampled only in IDLE or DONE
- key_in  in  KEY_SIZE  master key, bit 0 = MSB ([0:KEY_SIZE-1] ordering)
- delta_in  in  SIDE_SIZE  initial delta
- rk  out  SIDE_SIZE  current round key
- rk_valid  out  1  rk valid
- rk_ready  in  1  consumer accepts rk
- round_idx  out  CNT_W  index of the round key currently presented (0..ROUNDS-1)
- busy  out  1  high in RUN
- done  out  1  high in DONE
- final_key  out  KEY_SIZE  key state after last round
- final_delta  out  SIDE_SIZE  delta state after last round

Behaviour:
- Interface: one clock; reset is synchronous and active-low, ports clk and rst_n.
- State registers: K[0:255], D[31:0], cnt, fsm ∈ {IDLE, RUN, DONE}.
- Step function, combinational from (K, D):
  - d' = D + DELTA0 (mod 2^32)
  - Kr = K rotated left by PD (Kr[i] = K[(i+PD) mod 256])
  - K' = {Kr[0:223], Kr[224:255] + d'} (mod 2^32)
  - rk = K'[224:255]
- Reset (rst_n=0 at edge): fsm=IDLE; K, D, cnt = 0; rk_valid, busy, done = 0; rk = 0 (rk is masked to 0 outside RUN); round_idx = 0; final_key, final_delta = 0.
- IDLE: start=1 → K←key_in, D←delta_in, cnt←0, fsm←RUN. start=0 → stay.
- RUN:
  - rk_valid=1, busy=1.
  - rk and round_idx=cnt are combinational from the registers. First rk appears the cycle after start is accepted (latency 1).
  - rk_valid && rk_ready → K←K', D←d', cnt←cnt+1.
  - On the handshake with cnt==ROUNDS-1 → fsm←DONE; the same edge loads final_key←K', final_delta←d'.
  - rk_ready=0 → all state held; rk stable (no change while valid and not accepted).
  - start ignored.
- DONE:
  - done=1, rk_valid=0.
  - final_key/final_delta held until the next load.
  - start=1 → same load as IDLE, fsm←RUN, done drops next cycle.
- Wrap rules: all 32-bit additions are modulo 2^32, with no carry into adjacent key words. D wraps silently. cnt never exceeds ROUNDS-1 in RUN.
- Reset mid-RUN: abort immediately to the reset values. No further rk is emitted and the partial run is discarded.
- Inverse property: running the decryption step ROUNDS times from (final_key, final_delta) yields rk values in reverse order and ends at (key_in, delta_in).

Test Plan:
- Reset, then key_in=0, delta_in=0, start pulse, rk_ready=1 → cycle+1: rk_valid=1, round_idx=0, rk=32'h9e3779b9; next cycle round_idx=1, rk=32'hf56ef372; D sequence 9e3779b9, 3c6ef372.
- Same run with rk_ready=0 for 5 cycles at round_idx=1 → rk stays f56ef372 and round_idx stays 1; resumes correctly when rk_ready=1.
- Full run with random key, ROUNDS=64, rk_ready randomly toggled → exactly 64 handshakes and done=1 after the last. Feed final_key/final_delta to the decryption schedule → its 64 sk outputs equal the captured rk reversed, and its final state equals (key_in, delta_in).
- delta_in=32'hffffffff → first d'=32'h9e3779b8 (wrap), rk matches the reference model.
- start asserted repeatedly during RUN → ignored, round_idx increments normally. start in DONE → fresh run restarts at round_idx=0 with the new key.
- rst_n=0 at round_idx=10 → next cycle rk_valid=0, busy=0, done=0, all outputs 0, fsm in IDLE.

Source files
------------

// File: rtl/enc_key_schedule_256_seq.sv
// ============================================================================
// Module   : enc_key_schedule_256_seq
// Brief    : SWAN64 256-bit encryption-direction round-key generator, one key
//            per valid/ready handshake; exposes the final key/delta state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module enc_key_schedule_256_seq #(
  parameter int                    BLOCK_SIZE = 64,
  parameter int                    SIDE_SIZE  = BLOCK_SIZE / 2,
  parameter int                    KEY_SIZE   = 256,
  parameter int                    PD         = 24,
  parameter logic [SIDE_SIZE-1:0]  DELTA0     = 32'h9e3779b9,
  parameter int                    ROUNDS     = 64,
  parameter int                    CNT_W      = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KEY_SIZE-1:0]  key_in,
  input  logic [SIDE_SIZE-1:0] delta_in,
  output logic [SIDE_SIZE-1:0] rk,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [CNT_W-1:0]     round_idx,
  output logic                 busy,
  output logic                 done,
  output logic [KEY_SIZE-1:0]  final_key,
  output logic [SIDE_SIZE-1:0] final_delta
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  state_t               state_q;
  logic [KEY_SIZE-1:0]  key_q;
  logic [SIDE_SIZE-1:0] delta_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 rk_valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic [KEY_SIZE-1:0]  final_key_q;
  logic [SIDE_SIZE-1:0] final_delta_q;

  logic [KEY_SIZE-1:0]  key_rot;
  logic [KEY_SIZE-1:0]  key_d;
  logic [SIDE_SIZE-1:0] delta_d;
  logic                 hs;

  // Key bit 0 is the MSB, so the left rotation maps onto the packed vector
  // directly; the lowest 32-bit word is the one that absorbs the new delta.
  always_comb begin
    delta_d = delta_q + DELTA0;
    key_rot = {key_q[KEY_SIZE-PD-1:0], key_q[KEY_SIZE-1:KEY_SIZE-PD]};
    key_d   = {key_rot[KEY_SIZE-1:SIDE_SIZE],
               key_rot[SIDE_SIZE-1:0] + delta_d};
  end

  assign hs = rk_valid_q && rk_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      key_q         <= '0;
      delta_q       <= '0;
      cnt_q         <= '0;
      rk_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      final_key_q   <= '0;
      final_delta_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_RUN;
            key_q      <= key_in;
            delta_q    <= delta_in;
            cnt_q      <= '0;
            rk_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_RUN: begin
          if (hs) begin
            key_q   <= key_d;
            delta_q <= delta_d;
            if (cnt_q == LAST_CNT) begin
              // Counter parks at zero so round_idx reads 0 outside RUN.
              state_q       <= S_DONE;
              cnt_q         <= '0;
              rk_valid_q    <= 1'b0;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
              final_key_q   <= key_d;
              final_delta_q <= delta_d;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          rk_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rk          = rk_valid_q ? key_d[SIDE_SIZE-1:0] : '0;
  assign rk_valid    = rk_valid_q;
  assign round_idx   = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign final_key   = final_key_q;
  assign final_delta = final_delta_q;

endmodule

`default_nettype wire

// File: tb/tb_enc_key_schedule_256_seq.sv
// ============================================================================
// Module   : tb_enc_key_schedule_256_seq
// Brief    : Scoreboard bench for enc_key_schedule_256_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_enc_key_schedule_256_seq;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] key_in;
  logic [31:0]  delta_in;
  logic [31:0]  rk;
  logic         rk_valid;
  logic         rk_ready;
  logic [6:0]   round_idx;
  logic         busy;
  logic         done;
  logic [255:0] final_key;
  logic [31:0]  final_delta;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;

  logic [38:0]  sb[$];
  logic [31:0]  cap[$];
  logic [287:0] exp_final;

  enc_key_schedule_256_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .delta_in(delta_in), .rk(rk), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .round_idx(round_idx), .busy(busy), .done(done),
    .final_key(final_key), .final_delta(final_delta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference forward step on state {K[255:0], D[31:0]}.
  function automatic logic [287:0] fstep(input logic [287:0] s);
    logic [255:0] k, kr;
    logic [31:0]  d;
    k  = s[287:32];
    d  = s[31:0] + 32'h9e3779b9;
    kr = (k << 24) | (k >> 232);
    kr[31:0] = kr[31:0] + d;
    return {kr, d};
  endfunction

  // Reference decryption step: undo the word add, rotate right, undo delta.
  function automatic logic [287:0] istep(input logic [287:0] s);
    logic [255:0] k;
    logic [31:0]  d;
    k = s[287:32];
    d = s[31:0];
    k[31:0] = k[31:0] - d;
    k = (k >> 24) | (k << 232);
    return {k, d - 32'h9e3779b9};
  endfunction

  task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rk_valid && rk_ready) begin
      logic [38:0] e;
      hs_cnt++;
      cap.push_back(rk);
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got idx=%0d rk=%h with nothing expected", round_idx, rk);
      end else begin
        e = sb.pop_front();
        if ({round_idx, rk} !== e) begin
          fails++;
          $display("FAIL sb_rk: got idx=%0d rk=%h expected idx=%0d rk=%h",
                   round_idx, rk, e[38:32], e[31:0]);
        end
      end
    end
  end

  task automatic start_run(input logic [255:0] k, input logic [31:0] d);
    logic [287:0] s;
    s = {k, d};
    sb.delete();
    cap.delete();
    hs_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      s = fstep(s);
      sb.push_back({7'(i), s[63:32]});
    end
    exp_final = s;
    key_in   = k;
    delta_in = d;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input bit rnd_ready, input bit rnd_start);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd_start) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL done_timeout: got done=%0d expected 1 within 2000 cycles", done);
    end
  endtask

  task automatic check_done();
    chk("done_flag", 288'(done), 288'(1));
    chk("done_busy_valid", 288'({busy, rk_valid}), 288'(0));
    chk("done_rk", 288'(rk), 288'(0));
    chk("final_key", 288'(final_key), 288'(exp_final[287:32]));
    chk("final_delta", 288'(final_delta), 288'(exp_final[31:0]));
    chk("handshakes", 288'(hs_cnt), 288'(64));
    chk("sb_drained", 288'(sb.size()), 288'(0));
  endtask

  task automatic inv_check(input logic [255:0] k, input logic [31:0] d);
    logic [287:0] s;
    chk("cap_size", 288'(cap.size()), 288'(64));
    if (cap.size() == 64) begin
      s = {final_key, final_delta};
      for (int i = 0; i < 64; i++) begin
        chk("inv_rk", 288'(s[63:32]), 288'(cap[63-i]));
        s = istep(s);
      end
      chk("inv_state", s, {k, d});
    end
  endtask

  initial begin
    logic [255:0] rkey;
    bit           hit;
    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0;
    key_in = '0; delta_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", 288'({rk_valid, busy, done}), 288'(0));
    chk("rst_rk_idx", 288'({round_idx, rk}), 288'(0));
    chk("rst_final", 288'({final_key, final_delta}), 288'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero key/delta with a 5-cycle stall at round 1.
    rk_ready = 1'b1;
    start_run('0, '0);
    chk("t1_valid_busy", 288'({rk_valid, busy}), 288'(3));
    chk("t1_idx0", 288'(round_idx), 288'(0));
    chk("t1_rk0", 288'(rk), 288'(32'h9e3779b9));
    @(posedge clk); #1;
    chk("t1_idx1", 288'(round_idx), 288'(1));
    chk("t1_rk1", 288'(rk), 288'(32'hf56ef372));
    rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_rk", 288'(rk), 288'(32'hf56ef372));
      chk("stall_idx", 288'(round_idx), 288'(1));
    end
    wait_done(1'b0, 1'b0);
    check_done();
    inv_check('0, '0);

    // Restart from DONE with a random key; random ready and start noise.
    for (int i = 0; i < 8; i++) rkey[i*32 +: 32] = $urandom;
    start_run(rkey, 32'h01234567);
    chk("restart_done_low", 288'(done), 288'(0));
    chk("restart_idx0", 288'(round_idx), 288'(0));
    wait_done(1'b1, 1'b1);
    check_done();
    inv_check(rkey, 32'h01234567);

    // Delta wrap.
    rk_ready = 1'b1;
    start_run('0, 32'hffffffff);
    chk("wrap_rk0", 288'(rk), 288'(32'h9e3779b8));
    wait_done(1'b1, 1'b0);
    check_done();
    inv_check('0, 32'hffffffff);

    // Reset at round 10.
    for (int i = 0; i < 8; i++) rkey[i*32 +: 32] = $urandom;
    rk_ready = 1'b1;
    start_run(rkey, 32'hdeadbeef);
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (round_idx == 7'd10) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reach_idx10", 288'(hit), 288'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    chk("abort_flags", 288'({rk_valid, busy, done}), 288'(0));
    chk("abort_rk_idx", 288'({round_idx, rk}), 288'(0));
    chk("abort_final", 288'({final_key, final_delta}), 288'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", 288'({rk_valid, busy, done}), 288'(0));

    // Clean run from IDLE after the abort.
    start_run(rkey, 32'h0badf00d);
    wait_done(1'b1, 1'b0);
    check_done();
    inv_check(rkey, 32'h0badf00d);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
